// File: rtl/rbe_binconv_accum.sv
// Bit-plane popcount accumulator: shift/negate each beat, accumulate, emit one result per run.
// Optional saturation with sticky overflow flag: define RBE_BINCONV_ACCUM_SAT_EN.
module rbe_binconv_accum #(
    parameter  int TP      = 32,
    parameter  int ACC_W   = 32,
    parameter  int SHIFT_W = 4,
    parameter  int CNT_W   = 16,
    localparam int POP_W   = $clog2(TP) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   len_i,
    input  logic               pop_valid_i,
    output logic               pop_ready_o,
    input  logic [POP_W-1:0]   pop_data_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               negate_i,
    output logic               acc_valid_o,
    input  logic               acc_ready_i,
    output logic [ACC_W-1:0]   acc_data_o,
    output logic               busy_o,
    output logic               overflow_o
);

    localparam int TERM_W = POP_W + 2**SHIFT_W - 1;
    localparam int EXT_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 2;

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   len_q, cnt_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [EXT_W-1:0]   term, acc_ext, sum;
    logic               pop_hs, last_beat;

    assign pop_ready_o = (state_q == ACCUM) & enable_i;
    assign acc_valid_o = (state_q == OUTPUT) & enable_i;
    assign acc_data_o  = acc_q;
    assign busy_o      = (state_q != IDLE);
    assign pop_hs      = pop_valid_i & pop_ready_o;
    assign last_beat   = (cnt_q == len_q - CNT_W'(1));

    // Wide enough that a single update can never overflow before reduction to ACC_W.
    always_comb begin
        term    = EXT_W'(pop_data_i) << shift_i;
        acc_ext = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        sum     = negate_i ? (acc_ext - term) : (acc_ext + term);
    end

`ifdef RBE_BINCONV_ACCUM_SAT_EN
    localparam logic [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (ACC_W-1)) - EXT_W'(1);
    localparam logic [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic ovf_evt, ovf_q;

    always_comb begin
        ovf_evt = 1'b0;
        acc_d   = sum[ACC_W-1:0];
        if ($signed(sum) > $signed(SAT_MAX)) begin
            ovf_evt = 1'b1;
            acc_d   = SAT_MAX[ACC_W-1:0];
        end else if ($signed(sum) < $signed(SAT_MIN)) begin
            ovf_evt = 1'b1;
            acc_d   = SAT_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      ovf_q <= 1'b0;
        else if (clear_i) ovf_q <= 1'b0;
        else if (pop_hs)  ovf_q <= ovf_q | ovf_evt;
    end

    assign overflow_o = ovf_q;
`else
    logic unused_sum_hi;

    assign acc_d         = sum[ACC_W-1:0];
    assign unused_sum_hi = ^sum[EXT_W-1:ACC_W];
    assign overflow_o    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (enable_i) begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && len_i != '0) begin
                        state_q <= ACCUM;
                        len_q   <= len_i;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                ACCUM: begin
                    if (pop_hs) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_beat) state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    // A start_i coinciding with this handshake is dropped: we leave via IDLE first.
                    if (acc_ready_i) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rbe_binconv_accum.sv
// Scoreboard bench for rbe_binconv_accum: 32-bit main instance plus an 8-bit instance for overflow.
module tb_rbe_binconv_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // main instance (ACC_W=32)
    logic        rst_n = 1'b0, enable = 1'b1, clear = 1'b0, start = 1'b0;
    logic [15:0] len = '0;
    logic        pop_valid = 1'b0, pop_ready, negate = 1'b0;
    logic [5:0]  pop_data = '0;
    logic [3:0]  shift = '0;
    logic        acc_valid, acc_ready = 1'b1, busy, ovf;
    logic [31:0] acc_data;

    rbe_binconv_accum #(.TP(32), .ACC_W(32), .SHIFT_W(4), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
        .start_i(start), .len_i(len), .pop_valid_i(pop_valid), .pop_ready_o(pop_ready),
        .pop_data_i(pop_data), .shift_i(shift), .negate_i(negate),
        .acc_valid_o(acc_valid), .acc_ready_i(acc_ready), .acc_data_o(acc_data),
        .busy_o(busy), .overflow_o(ovf)
    );

    // narrow instance (ACC_W=8)
    logic        start8 = 1'b0, clear8 = 1'b0, pop_valid8 = 1'b0, pop_ready8;
    logic [15:0] len8 = '0;
    logic [5:0]  pop_data8 = '0;
    logic [3:0]  shift8 = '0;
    logic        acc_valid8, busy8, ovf8;
    logic [7:0]  acc_data8;

    rbe_binconv_accum #(.TP(32), .ACC_W(8), .SHIFT_W(4), .CNT_W(16)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(1'b1), .clear_i(clear8),
        .start_i(start8), .len_i(len8), .pop_valid_i(pop_valid8), .pop_ready_o(pop_ready8),
        .pop_data_i(pop_data8), .shift_i(shift8), .negate_i(1'b0),
        .acc_valid_o(acc_valid8), .acc_ready_i(1'b1), .acc_data_o(acc_data8),
        .busy_o(busy8), .overflow_o(ovf8)
    );

`ifdef RBE_BINCONV_ACCUM_SAT_EN
    localparam logic [7:0] EXP8     = 8'd127;
    localparam logic       EXP_OVF8 = 1'b1;
`else
    localparam logic [7:0] EXP8     = 8'h80;
    localparam logic       EXP_OVF8 = 1'b0;
`endif

    logic [31:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitors: a handshake seen at negedge completes on the following posedge
    always @(negedge clk) begin
        if (rst_n && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", acc_data, 32'hDEAD_BEEF);
            else check("result", acc_data, exp_q.pop_front());
        end
        if (rst_n && acc_valid8) begin
            if (exp8_q.size() == 0) check("unexpected_result8", 32'(acc_data8), 32'hDEAD_BEEF);
            else check("result8", 32'(acc_data8), 32'(exp8_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic start_run(input logic [15:0] l);
        start = 1'b1; len = l;
        cyc();
        start = 1'b0;
    endtask

    task automatic beat(input logic [5:0] d, input logic [3:0] s, input logic n);
        bit ok = 1'b0;
        pop_valid = 1'b1; pop_data = d; shift = s; negate = n;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pop_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("beat_timeout", 32'(pop_ready), 32'd1);
        cyc();
        pop_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_pop_ready", 32'(pop_ready), 0);
        check("rst_acc_valid", 32'(acc_valid), 0);
        check("rst_acc_data", acc_data, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        cyc(); rst_n = 1'b1; cyc();

        // zero-length start is ignored
        start_run(16'd0);
        check("len0_ignored", 32'(busy), 0);

        // 1: 1+2+3+4
        exp_q.push_back(32'd10);
        start_run(16'd4);
        check("t1_busy", 32'(busy), 1);
        beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 0); beat(4, 0, 0);
        check("t1_latency_valid", 32'(acc_valid), 1);
        check("t1_data", acc_data, 32'd10);
        cyc();
        check("t1_busy_fall", 32'(busy), 0);

        // 2: 5 + 10 - 20
        exp_q.push_back(32'hFFFF_FFFB);
        start_run(16'd3);
        beat(5, 0, 0); beat(5, 1, 0); beat(5, 2, 1);
        wait_idle();

        // 3: backpressure, start_i ignored while holding and at the handshake
        exp_q.push_back(32'd12);
        start_run(16'd2);
        acc_ready = 1'b0;
        beat(6, 0, 0); beat(6, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(acc_valid), 1);
            check("t3_hold_data", acc_data, 32'd12);
            check("t3_hold_pop_ready", 32'(pop_ready), 0);
            start = 1'b1; len = 16'd2;
            cyc();
        end
        acc_ready = 1'b1;
        cyc();
        start = 1'b0;
        check("t3_start_at_hs_ignored", 32'(busy), 0);

        // 4a: clear mid-run, then a clean run
        start_run(16'd4);
        beat(1, 0, 0); beat(2, 0, 0);
        clear = 1'b1; cyc(); clear = 1'b0;
        check("t4_clear_busy", 32'(busy), 0);
        check("t4_clear_data", acc_data, 0);
        check("t4_clear_pop_ready", 32'(pop_ready), 0);
        exp_q.push_back(32'd14);
        start_run(16'd2);
        beat(7, 0, 0); beat(7, 0, 0);
        wait_idle();

        // 4b: async reset mid-run
        start_run(16'd3);
        beat(1, 0, 0);
        rst_n = 1'b0; #2;
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_data", acc_data, 0);
        check("t4_rst_pop_ready", 32'(pop_ready), 0);
        check("t4_rst_valid", 32'(acc_valid), 0);
        cyc(); rst_n = 1'b1; cyc();
        check("t4_after_rst_busy", 32'(busy), 0);

        // 6: enable low mid-ACCUM, then enable low in OUTPUT
        exp_q.push_back(32'd3);
        start_run(16'd3);
        beat(1, 0, 0);
        enable = 1'b0; pop_valid = 1'b1; pop_data = 6'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_frozen_pop_ready", 32'(pop_ready), 0);
        end
        cyc();
        enable = 1'b1;
        acc_ready = 1'b0;
        beat(1, 0, 0); beat(1, 0, 0);
        enable = 1'b0;
        #1;
        check("t6_dis_valid", 32'(acc_valid), 0);
        check("t6_dis_data", acc_data, 32'd3);
        cyc(); cyc();
        check("t6_dis_busy", 32'(busy), 1);
        enable = 1'b1; acc_ready = 1'b1;
        wait_idle();

        // 5: 32<<2 = 128 on an 8-bit accumulator
        exp8_q.push_back(EXP8);
        start8 = 1'b1; len8 = 16'd1; cyc(); start8 = 1'b0;
        pop_valid8 = 1'b1; pop_data8 = 6'd32; shift8 = 4'd2;
        @(negedge clk);
        check("t5_pop_ready8", 32'(pop_ready8), 1);
        cyc(); pop_valid8 = 1'b0;
        check("t5_valid8", 32'(acc_valid8), 1);
        check("t5_ovf8", 32'(ovf8), 32'(EXP_OVF8));
        cyc(); cyc(); cyc();
        check("t5_busy8", 32'(busy8), 0);
        check("t5_ovf8_sticky", 32'(ovf8), 32'(EXP_OVF8));
        clear8 = 1'b1; cyc(); clear8 = 1'b0;
        check("t5_ovf8_cleared", 32'(ovf8), 0);
        check("t5_main_ovf", 32'(ovf), 0);

        cyc(); cyc();
        check("scoreboard_drained", 32'(exp_q.size() + exp8_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
